// File: rtl/nbitctr_pkg.sv
// Shared types and helpers for the parametrised up/down counter family.
package nbitctr_pkg;

  typedef enum logic [1:0] {
    WRAP    = 2'd0,
    SAT     = 2'd1,
    ONESHOT = 2'd2
  } ctr_mode_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } ctr_state_t;

  // Values at or above the modulus are clamped to the top of the range.
  function automatic int unsigned clamp_load(int unsigned val, int unsigned modulus);
    return (val < modulus) ? val : modulus - 1;
  endfunction

endpackage

// File: rtl/nbitctr_next.sv
// Combinational next-value and terminal-count logic for nbit_updown_counter.
module nbitctr_next
  import nbitctr_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned MODULUS = 2**N
) (
  input  logic [N-1:0] y,
  input  logic         UP,
  input  logic [1:0]   MODE,
  output logic [N-1:0] next_y,
  output logic         at_term,
  output logic         wrap
);

  // Compare one bit wider so MODULUS == 2**N does not truncate the top value.
  localparam logic [N:0]   TERM_HI = (N+1)'(MODULUS - 1);
  localparam logic [N:0]   TERM_LO = '0;
  localparam logic [N-1:0] ONE_N   = N'(1);

  logic [N:0]   y_ext;
  logic [N-1:0] step_y;

  always_comb begin
    y_ext   = {1'b0, y};
    at_term = UP ? (y_ext == TERM_HI) : (y_ext == TERM_LO);
    // Reserved encoding 3 falls through to wrap behaviour.
    wrap    = (MODE != SAT) && (MODE != ONESHOT);
    step_y  = UP ? (y + ONE_N) : (y - ONE_N);

    if (!at_term) begin
      next_y = step_y;
    end else if (wrap) begin
      next_y = UP ? '0 : TERM_HI[N-1:0];
    end else begin
      next_y = y;
    end
  end

endmodule

// File: rtl/nbit_updown_counter.sv
// Synchronous up/down counter with modulus, end-of-range modes, cascade carry
// and sticky overflow. Define NBITCTR_CAPTURE_EN to add the CAPTURE/CAP snapshot port.
module nbit_updown_counter
  import nbitctr_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned MODULUS = 2**N
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         CLEAR,
  input  logic         LOAD,
  input  logic         COUNT,
  input  logic         CEI,
  input  logic         UP,
  input  logic [1:0]   MODE,
  input  logic [N-1:0] in,
`ifdef NBITCTR_CAPTURE_EN
  input  logic         CAPTURE,
  output logic [N-1:0] CAP,
`endif
  output logic [N-1:0] y,
  output logic         TC,
  output logic         CO,
  output logic         DONE,
  output logic         OVF
);

  ctr_state_t   state_q, state_d;
  logic [N-1:0] y_q, y_d;
  logic         done_q, done_d;
  logic         ovf_q, ovf_d;

  logic [N-1:0] next_y;
  logic [N-1:0] load_val;
  logic         at_term;
  logic         wrap;
  logic         step;

  nbitctr_next #(
    .N       (N),
    .MODULUS (MODULUS)
  ) u_next (
    .y       (y_q),
    .UP      (UP),
    .MODE    (MODE),
    .next_y  (next_y),
    .at_term (at_term),
    .wrap    (wrap)
  );

  always_comb begin
    load_val = N'(clamp_load(32'(in), MODULUS));
    step     = COUNT && CEI && (state_q == RUN);

    y_d     = y_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    state_d = state_q;

    if (CLEAR) begin
      y_d     = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      state_d = RUN;
    end else if (LOAD) begin
      y_d     = load_val;
      done_d  = 1'b0;
      state_d = RUN;
    end else if (step) begin
      if (!at_term) begin
        y_d = next_y;
      end else if (wrap) begin
        y_d   = next_y;
        ovf_d = 1'b1;
      end else if (MODE == ONESHOT) begin
        state_d = HALT;
        done_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      y_q     <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= RUN;
    end else begin
      y_q     <= y_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

`ifdef NBITCTR_CAPTURE_EN
  logic [N-1:0] cap_q, cap_d;

  // Snapshot uses the pre-edge value, independent of clear/load/step priority.
  always_comb begin
    cap_d = cap_q;
    if (CAPTURE) begin
      cap_d = y_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cap_q <= '0;
    end else begin
      cap_q <= cap_d;
    end
  end

  assign CAP = cap_q;
`endif

  assign y    = y_q;
  assign TC   = at_term;
  assign CO   = at_term && COUNT && CEI;
  assign DONE = done_q;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_nbit_updown_counter.sv
// Scoreboard bench for nbit_updown_counter (N=4, MODULUS=10), including a two-stage cascade.
module tb_nbit_updown_counter;

  logic       clk = 1'b0;
  logic       rst, clr, ld, cnt, up, rst1;
  logic [1:0] md;
  logic [3:0] din;
  logic [3:0] y0, y1;
  logic       tc0, co0, done0, ovf0;
  logic       tc1, co1, done1, ovf1;
`ifdef NBITCTR_CAPTURE_EN
  logic       cap_en;
  logic [3:0] cap0, cap1;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [3:0] y;
    logic       tc;
    logic       co;
    logic       done;
    logic       ovf;
    logic       chk1;
    logic [3:0] y1;
    logic       co1;
    logic       chkc;
    logic [3:0] cap;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;

  always #5 clk = ~clk;

  nbit_updown_counter #(.N(4), .MODULUS(10)) u0 (
    .CLK     (clk),
    .RESET   (rst),
    .CLEAR   (clr),
    .LOAD    (ld),
    .COUNT   (cnt),
    .CEI     (1'b1),
    .UP      (up),
    .MODE    (md),
    .in      (din),
`ifdef NBITCTR_CAPTURE_EN
    .CAPTURE (cap_en),
    .CAP     (cap0),
`endif
    .y       (y0),
    .TC      (tc0),
    .CO      (co0),
    .DONE    (done0),
    .OVF     (ovf0)
  );

  nbit_updown_counter #(.N(4), .MODULUS(10)) u1 (
    .CLK     (clk),
    .RESET   (rst1),
    .CLEAR   (1'b0),
    .LOAD    (1'b0),
    .COUNT   (cnt),
    .CEI     (co0),
    .UP      (1'b1),
    .MODE    (2'd0),
    .in      (4'd0),
`ifdef NBITCTR_CAPTURE_EN
    .CAPTURE (1'b0),
    .CAP     (cap1),
`endif
    .y       (y1),
    .TC      (tc1),
    .CO      (co1),
    .DONE    (done1),
    .OVF     (ovf1)
  );

  task automatic chk(input string nm, input string fld, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s.%s got=%0d want=%0d at %0t", nm, fld, got, want, $time);
    end
  endtask

  // Monitor: one expectation per observation cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e_mon = q.pop_front();
      chk(e_mon.name, "y",    y0,             e_mon.y);
      chk(e_mon.name, "TC",   {3'b0, tc0},    {3'b0, e_mon.tc});
      chk(e_mon.name, "CO",   {3'b0, co0},    {3'b0, e_mon.co});
      chk(e_mon.name, "DONE", {3'b0, done0},  {3'b0, e_mon.done});
      chk(e_mon.name, "OVF",  {3'b0, ovf0},   {3'b0, e_mon.ovf});
      if (e_mon.chk1) begin
        chk(e_mon.name, "y1",  y1,          e_mon.y1);
        chk(e_mon.name, "CO1", {3'b0, co1}, {3'b0, e_mon.co1});
      end
`ifdef NBITCTR_CAPTURE_EN
      if (e_mon.chkc) begin
        chk(e_mon.name, "CAP", cap0, e_mon.cap);
      end
`endif
    end
  end

  task automatic push_full(input string nm, input logic [3:0] ey, input logic etc, input logic eco,
                           input logic edone, input logic eovf, input logic c1, input logic [3:0] ey1,
                           input logic eco1, input logic cc, input logic [3:0] ecap);
    exp_t e;
    e.name = nm;  e.y = ey;   e.tc = etc;  e.co = eco; e.done = edone; e.ovf = eovf;
    e.chk1 = c1;  e.y1 = ey1; e.co1 = eco1;
    e.chkc = cc;  e.cap = ecap;
    q.push_back(e);
  endtask

  task automatic push(input string nm, input logic [3:0] ey, input logic etc, input logic eco,
                      input logic edone, input logic eovf);
    push_full(nm, ey, etc, eco, edone, eovf, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic push_c(input string nm, input logic [3:0] ey, input logic etc, input logic eco,
                        input logic edone, input logic eovf, input logic [3:0] ey1, input logic eco1);
    push_full(nm, ey, etc, eco, edone, eovf, 1'b1, ey1, eco1, 1'b0, 4'd0);
  endtask

  task automatic push_cap(input string nm, input logic [3:0] ey, input logic etc, input logic eco,
                          input logic edone, input logic eovf, input logic [3:0] ecap);
    push_full(nm, ey, etc, eco, edone, eovf, 1'b0, 4'd0, 1'b0, 1'b1, ecap);
  endtask

  task automatic drv(input logic r, input logic c, input logic l, input logic n, input logic u,
                     input logic [1:0] m, input logic [3:0] v);
    rst = r; clr = c; ld = l; cnt = n; up = u; md = m; din = v;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout got=running want=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0);
    rst1 = 1'b1;
`ifdef NBITCTR_CAPTURE_EN
    cap_en = 1'b0;
`endif
    tick;
    tick;

    drv(0, 0, 0, 0, 1, 2'd0, 4'd0);
`ifdef NBITCTR_CAPTURE_EN
    push_cap("reset", 4'd0, 0, 0, 0, 0, 4'd0);
`else
    push("reset", 4'd0, 0, 0, 0, 0);
`endif

    // Up-count in WRAP across 9 -> 0.
    for (int i = 0; i < 12; i++) begin
      tick;
      drv(0, 0, 0, 1, 1, 2'd0, 4'd0);
      push("wrap", 4'(i % 10), (i % 10) == 9, (i % 10) == 9, 1'b0, i >= 10);
    end

    tick; drv(0, 1, 0, 0, 1, 2'd0, 4'd0); push("pre_clr", 4'd2, 0, 0, 0, 1);
    tick; drv(0, 0, 1, 0, 1, 2'd0, 4'd3); push("clr",     4'd0, 0, 0, 0, 0);

    // Down-count in SAT from 3, blocked at 0.
    for (int j = 0; j < 6; j++) begin
      tick;
      drv(0, 0, 0, 1, 0, 2'd1, 4'd0);
      push("sat", (j < 3) ? 4'(3 - j) : 4'd0, j >= 3, j >= 3, 1'b0, j >= 4);
    end

    tick; drv(0, 1, 0, 0, 1, 2'd0, 4'd0); push("sat_end",   4'd0, 0, 0, 0, 1);
    tick; drv(0, 0, 1, 0, 1, 2'd2, 4'd7); push("sat_clr",   4'd0, 0, 0, 0, 0);
    tick; drv(0, 0, 0, 1, 1, 2'd2, 4'd0); push("os_load",   4'd7, 0, 0, 0, 0);
    tick;                                 push("os_8",      4'd8, 0, 0, 0, 0);
    tick;                                 push("os_9",      4'd9, 1, 1, 0, 0);
    tick;                                 push("os_done",   4'd9, 1, 1, 1, 0);
    tick; drv(0, 0, 0, 1, 1, 2'd0, 4'd0); push("os_halt",   4'd9, 1, 1, 1, 0);
    tick; drv(0, 0, 1, 1, 1, 2'd2, 4'd2); push("os_hold",   4'd9, 1, 1, 1, 0);
    tick; drv(0, 0, 0, 1, 1, 2'd2, 4'd0); push("os_reload", 4'd2, 0, 0, 0, 0);
    tick; drv(0, 0, 1, 0, 1, 2'd0, 4'd15); push("os_resume", 4'd3, 0, 0, 0, 0);
    tick; drv(0, 0, 0, 0, 1, 2'd0, 4'd0); push("clamp",     4'd9, 1, 0, 0, 0);
    tick; drv(0, 1, 1, 1, 1, 2'd0, 4'd5); push("prio_pre",  4'd9, 1, 1, 0, 0);
    tick; drv(0, 0, 1, 0, 1, 2'd0, 4'd9); push("clr_prio",  4'd0, 0, 0, 0, 0);
    tick; drv(0, 0, 0, 1, 1, 2'd0, 4'd0); push("ld9",       4'd9, 1, 1, 0, 0);
    tick; drv(1, 1, 1, 1, 1, 2'd0, 4'd6); push("pre_rst",   4'd0, 0, 0, 0, 1);
    tick; drv(0, 0, 0, 1, 0, 2'd3, 4'd0); push("reset_all", 4'd0, 1, 1, 0, 0);
    tick; drv(0, 0, 0, 0, 1, 2'd0, 4'd0); push("down_wrap", 4'd9, 1, 0, 0, 1);

    // Two-stage decimal cascade.
    tick; drv(0, 1, 0, 0, 1, 2'd0, 4'd0); push("cas_pre", 4'd9, 1, 0, 0, 1);
    tick; drv(0, 0, 0, 0, 1, 2'd0, 4'd0); rst1 = 1'b0;
    push_c("cas_start", 4'd0, 0, 0, 0, 0, 4'd0, 1'b0);
    for (int k = 0; k <= 100; k++) begin
      tick;
      drv(0, 0, 0, 1, 1, 2'd0, 4'd0);
      push_c("cascade", 4'(k % 10), (k % 10) == 9, (k % 10) == 9, 1'b0, k >= 10,
             4'((k / 10) % 10), (k % 100) == 99);
    end

`ifdef NBITCTR_CAPTURE_EN
    tick; drv(0, 0, 1, 0, 1, 2'd0, 4'd5); push("cap_pre", 4'd1, 0, 0, 0, 1);
    tick; drv(0, 0, 0, 1, 1, 2'd0, 4'd0); cap_en = 1'b1; push("cap_y5", 4'd5, 0, 0, 0, 1);
    tick; drv(0, 0, 0, 0, 1, 2'd0, 4'd0); cap_en = 1'b0; push_cap("cap_5", 4'd6, 0, 0, 0, 1, 4'd5);
    tick; drv(0, 1, 0, 0, 1, 2'd0, 4'd0); push_cap("cap_clr",  4'd6, 0, 0, 0, 1, 4'd5);
    tick; drv(0, 0, 0, 0, 1, 2'd0, 4'd0); push_cap("cap_keep", 4'd0, 0, 0, 0, 0, 4'd5);
`endif

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
